// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline, with a memory-wait/timeout FSM.
// Optional performance counters are compiled in with `define HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic             exmem_branch,
  input  logic             exmem_zero,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_enable,
  output logic             pc_src,
  output logic             if_id_enable,
  output logic             if_id_flush,
  output logic             id_ex_enable,
  output logic             id_ex_flush,
  output logic             ex_mem_enable,
  output logic             ex_mem_flush,
  output logic             mem_wb_enable,
  output logic             mem_wb_flush,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam logic [8:0] TIMEOUT_C = 9'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [8:0] wait_next_s;
  logic       br_taken_s, mem_stall_s, load_use_s;

  assign br_taken_s  = exmem_branch & exmem_zero;
  assign mem_stall_s = mem_req & ~mem_ready;
  assign load_use_s  = idex_memread & (idex_rt != 5'd0) &
                       ((idex_rt == id_rs) | (id_uses_rt & (idex_rt == id_rt)));

  // Control outputs and next state, with priority branch > memory stall > load-use > normal.
  always_comb begin
    pc_enable     = 1'b1;
    pc_src        = 1'b0;
    if_id_enable  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_enable  = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_enable = 1'b1;
    ex_mem_flush  = 1'b0;
    mem_wb_enable = 1'b1;
    mem_wb_flush  = 1'b0;
    mem_error     = 1'b0;
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    wait_next_s   = 9'd1;
    if (reset) begin
      state_d    = RUN;
      wait_cnt_d = 8'd0;
    end else begin
      case (state_q)
        RUN, MEM_WAIT: begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
          if (br_taken_s) begin
            pc_src       = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
          end else if (mem_stall_s) begin
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            id_ex_enable  = 1'b0;
            ex_mem_enable = 1'b0;
            mem_wb_flush  = 1'b1;
            // wait_next_s is the number of stalled cycles including this one
            if (state_q == MEM_WAIT) begin
              wait_next_s = {1'b0, wait_cnt_q} + 9'd1;
            end else begin
              wait_next_s = 9'd1;
            end
            if (wait_next_s >= TIMEOUT_C) begin
              state_d = ERROR;
            end else begin
              state_d    = MEM_WAIT;
              wait_cnt_d = wait_next_s[7:0];
            end
          end else if (load_use_s) begin
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            id_ex_flush  = 1'b1;
          end else begin
            pc_src = 1'b0;
          end
        end
        ERROR: begin
          pc_enable     = 1'b0;
          if_id_enable  = 1'b0;
          id_ex_enable  = 1'b0;
          ex_mem_enable = 1'b0;
          mem_wb_enable = 1'b0;
          mem_error     = 1'b1;
          state_d       = ERROR;
          wait_cnt_d    = 8'd0;
        end
        default: begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end
      endcase
    end
  end

  // FSM state and memory-wait counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating counters of frozen-PC cycles and flushed taken branches.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_enable && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (pc_src && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected control vectors are queued per step and checked mid-cycle.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [4:0]  id_rs, id_rt, idex_rt;
  logic        id_uses_rt, idex_memread, exmem_branch, exmem_zero, mem_req, mem_ready;
  logic        pc_enable, pc_src, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush;
  logic        ex_mem_enable, ex_mem_flush, mem_wb_enable, mem_wb_flush, mem_error;
  logic [31:0] stall_count, flush_count;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .idex_memread(idex_memread), .idex_rt(idex_rt),
    .exmem_branch(exmem_branch), .exmem_zero(exmem_zero),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_enable(pc_enable), .pc_src(pc_src),
    .if_id_enable(if_id_enable), .if_id_flush(if_id_flush),
    .id_ex_enable(id_ex_enable), .id_ex_flush(id_ex_flush),
    .ex_mem_enable(ex_mem_enable), .ex_mem_flush(ex_mem_flush),
    .mem_wb_enable(mem_wb_enable), .mem_wb_flush(mem_wb_flush),
    .mem_error(mem_error), .stall_count(stall_count), .flush_count(flush_count)
  );

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_en, pc_src, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl, memwb_en, memwb_fl, mem_error}
  localparam logic [10:0] NRM = 11'b10101010100;
  localparam logic [10:0] BRN = 11'b11111111100;
  localparam logic [10:0] MST = 11'b00000000110;
  localparam logic [10:0] LDU = 11'b00001110100;
  localparam logic [10:0] ERR = 11'b00000000001;

  typedef struct {
    string       tag;
    logic [10:0] ctl;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_stall = 32'd0;
  logic [31:0] exp_flush = 32'd0;
  logic [10:0] obs;

  assign obs = {pc_enable, pc_src, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush,
                ex_mem_enable, ex_mem_flush, mem_wb_enable, mem_wb_flush, mem_error};

  task automatic step(input string tag, input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic ur, input logic mr, input logic [4:0] xrt, input logic br,
                      input logic z, input logic rq, input logic rd, input logic [10:0] ctl);
    exp_t e;
    reset = r; id_rs = rs; id_rt = rt; id_uses_rt = ur; idex_memread = mr; idex_rt = xrt;
    exmem_branch = br; exmem_zero = z; mem_req = rq; mem_ready = rd;
    sb.push_back('{tag, ctl, PERF ? exp_stall : 32'd0, PERF ? exp_flush : 32'd0});
    #4;
    e = sb.pop_front();
    n_checks++;
    assert (obs === e.ctl) else begin
      n_fail++;
      $error("FAIL %s ctl observed=%b expected=%b", e.tag, obs, e.ctl);
    end
    n_checks++;
    assert (stall_count === e.sc) else begin
      n_fail++;
      $error("FAIL %s stall_count observed=%0d expected=%0d", e.tag, stall_count, e.sc);
    end
    n_checks++;
    assert (flush_count === e.fc) else begin
      n_fail++;
      $error("FAIL %s flush_count observed=%0d expected=%0d", e.tag, flush_count, e.fc);
    end
    if (r) begin
      exp_stall = 32'd0;
      exp_flush = 32'd0;
    end else begin
      if (!ctl[10] && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'd1;
      if (ctl[9] && exp_flush != 32'hFFFF_FFFF) exp_flush = exp_flush + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; idex_memread = 1'b0;
    idex_rt = 5'd0; exmem_branch = 1'b0; exmem_zero = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    //   tag            r  rs     rt     ur    mr    xrt    br    z     rq    rd
    step("rst_idle",   1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NRM);
    step("rst_forced", 1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, NRM);
    step("idle",       1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NRM);
    // load-use on rs: exactly one bubble
    step("lu_rs",      1'b0, 5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, LDU);
    step("lu_after",   1'b0, 5'd5, 5'd2, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, NRM);
    step("zero_exempt",1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NRM);
    step("rt_unused",  1'b0, 5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, NRM);
    step("lu_rt",      1'b0, 5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, LDU);
    step("no_lu_read", 1'b0, 5'd1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, NRM);
    // taken branch beats load-use and memory stall; untaken branch is normal
    step("br_over_lu", 1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, BRN);
    step("br_untaken", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, NRM);
    step("br_over_mem",1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, BRN);
    step("idle2",      1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NRM);
    // three wait cycles, then ready together with a load-use
    step("mw1",        1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MST);
    step("mw2",        1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MST);
    step("mw3",        1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MST);
    step("mw_ready_lu",1'b0, 5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, LDU);
    step("mw_done",    1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, NRM);
    // timeout after four waiting cycles; error is sticky until reset
    step("to1",        1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MST);
    step("to2",        1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MST);
    step("to3",        1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MST);
    step("to4",        1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MST);
    step("err",        1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, ERR);
    step("err_ready",  1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, ERR);
    step("err_branch", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, ERR);
    step("err_rst",    1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NRM);
    step("post_err",   1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NRM);
    // reset in the middle of a memory wait forgets the wait
    step("rw1",        1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MST);
    step("rw2",        1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MST);
    step("rw_rst",     1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, NRM);
    step("rw_after",   1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NRM);
    step("rw_again1",  1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MST);
    step("rw_again2",  1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MST);
    step("rw_again3",  1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MST);
    step("rw_release", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, NRM);
    step("final",      1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NRM);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
